control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control FSM for the accumulator CPU. It sequences every instruction through fetch, decode and execute, and drives the enables of the PC, IR, accumulator, data memory and status register. It is the direct downstream consumer of the status register: its flag_Z/flag_N outputs select conditional branches. It is also the producer of that register's status_wr strobe.

## Interface
Parameters:
- OPCODE_WIDTH, 5, width of opcode field taken from the instruction register

Ports:
- clock  in  1  system clock, rising edge
- control_reset  in  1  synchronous, active-high reset
- opcode_in  in  OPCODE_WIDTH  opcode field of the IR output
- flag_Z  in  1  zero flag from status register
- flag_N  in  1  negative flag from status register
- ir_wr  out  1  load instruction register
- pc_wr  out  1  load program counter
- pc_src  out  1  0 = PC+1, 1 = IR operand (branch target)
- acc_wr  out  1  load accumulator
- acc_src  out  2  00 = data memory, 01 = immediate, 10 = ALU result
- alu_op  out  1  0 = add, 1 = subtract
- alu_src  out  1  0 = data memory, 1 = immediate
- data_mem_wr  out  1  store accumulator to data memory
- status_wr  out  1  update Z/N in status register
- halted  out  1  core stopped by HLT

## Operation
- States: FETCH, DECODE, EXEC, HALT. Reset state is FETCH.
- Transitions: FETCH→DECODE→EXEC→FETCH. EXEC with HLT→HALT. HALT→HALT until control_reset.
- FETCH: ir_wr=1; all other outputs 0.
- DECODE: all outputs 0. Opcode is stable and the data-memory read address (IR operand) settles.
- EXEC, by opcode:
  - 00000 HLT: pc_wr=0.
  - 00001 STO: data_mem_wr=1.
  - 00010 LD: acc_wr=1, acc_src=00.
  - 00011 LDI: acc_wr=1, acc_src=01.
  - 00100 ADD: acc_wr=1, acc_src=10, alu_op=0, alu_src=0, status_wr=1.
  - 00101 ADDI: as ADD with alu_src=1.
  - 00110 SUB: as ADD with alu_op=1.
  - 00111 SUBI: as SUB with alu_src=1.
  - 01000 BEQ: taken if Z.
  - 01001 BNE: taken if !Z.
  - 01010 BGT: taken if !Z&!N.
  - 01011 BGE: taken if !N.
  - 01100 BLT: taken if N.
  - 01101 BLE: taken if N|Z.
  - 01110 JMP: always taken.
  - All other opcodes: NOP.
- PC update: every non-HLT EXEC asserts pc_wr=1. pc_src=1 only for a taken branch or JMP, else 0.
- HALT: halted=1, all enables 0.
- Only ADD/ADDI/SUB/SUBI assert status_wr. LD, LDI and branches leave flags untouched.
- Outputs are combinational from the registered state, opcode_in and flags. Every output is forced to 0 while control_reset=1.

## Timing
- Three cycles per instruction. HLT reaches HALT on the edge ending its EXEC.
- Flags written by an arithmetic EXEC are valid from the next cycle. The earliest following branch samples them two cycles later, so no forwarding is needed.
- Branch condition is evaluated on flag values during the branch's EXEC cycle only.
- Reset values: state=FETCH. ir_wr, pc_wr, pc_src, acc_wr, acc_src, alu_op, alu_src, data_mem_wr, status_wr and halted are all 0.
- Reset mid-instruction (DECODE/EXEC/HALT): the pending writes are suppressed that cycle and the next cycle is FETCH. The control unit does not drive status_reset; the system reset handles the status register separately.
- opcode_in changing in DECODE/EXEC is a system error. The FSM follows it combinationally, with no latching.

## Structure
- Package cpu_pkg holds:
  - opcode_t enum (values above)
  - state_t enum {FETCH, DECODE, EXEC, HALT}
  - acc_src_t enum {ACC_MEM=2'b00, ACC_IMM=2'b01, ACC_ALU=2'b10}
  - ALU_ADD/ALU_SUB constants
- Sub-module branch_condition: combinational (opcode, flag_Z, flag_N) → taken. It is reused by the verification scoreboard.
- FSM: one registered state process plus one combinational output decoder.

## Test plan
- Reset then LDI (00011) → FETCH/DECODE/EXEC sequence with ir_wr pulse in cycle 1. EXEC shows acc_wr=1, acc_src=01, pc_wr=1, pc_src=0, status_wr=0.
- SUB (00110) → EXEC shows acc_src=10, alu_op=1, alu_src=0, status_wr=1, acc_wr=1, pc_wr=1.
- Drive Z=1,N=0 with each branch opcode 01000..01101 → pc_src equals 1,0,0,1,0,1 respectively; JMP → 1 for every flag combination.
- Opcode 11111 → EXEC has pc_wr=1, pc_src=0, all other enables 0.
- HLT (00000) → EXEC has pc_wr=0. Next cycle halted=1 and stays high for 10 cycles regardless of opcode_in. control_reset=1 → next cycle FETCH, halted=0.
- Assert control_reset during EXEC of STO → data_mem_wr=0 that cycle, FETCH with ir_wr=1 on the cycle after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states and datapath selects.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111,
    OP_BEQ  = 5'b01000,
    OP_BNE  = 5'b01001,
    OP_BGT  = 5'b01010,
    OP_BGE  = 5'b01011,
    OP_BLT  = 5'b01100,
    OP_BLE  = 5'b01101,
    OP_JMP  = 5'b01110
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    HALT   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ACC_MEM = 2'b00,
    ACC_IMM = 2'b01,
    ACC_ALU = 2'b10
  } acc_src_t;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface control_unit_if #(
  parameter int OPCODE_WIDTH = 5
);
  logic [OPCODE_WIDTH-1:0] opcode_in;
  logic                    flag_Z;
  logic                    flag_N;
  logic                    ir_wr;
  logic                    pc_wr;
  logic                    pc_src;
  logic                    acc_wr;
  logic [1:0]              acc_src;
  logic                    alu_op;
  logic                    alu_src;
  logic                    data_mem_wr;
  logic                    status_wr;
  logic                    halted;

  modport master (
    input  opcode_in, flag_Z, flag_N,
    output ir_wr, pc_wr, pc_src, acc_wr, acc_src, alu_op, alu_src,
           data_mem_wr, status_wr, halted
  );

  modport slave (
    output opcode_in, flag_Z, flag_N,
    input  ir_wr, pc_wr, pc_src, acc_wr, acc_src, alu_op, alu_src,
           data_mem_wr, status_wr, halted
  );
endinterface

// File: rtl/control_unit_branch_condition.sv
// Branch resolution from opcode and status flags; JMP is always taken,
// non-branch opcodes never are.
module branch_condition
  import cpu_pkg::*;
(
  input  opcode_t opcode,
  input  logic    flag_Z,
  input  logic    flag_N,
  output logic    taken
);

  always_comb begin
    unique case (opcode)
      OP_BEQ:  taken = flag_Z;
      OP_BNE:  taken = !flag_Z;
      OP_BGT:  taken = !flag_Z && !flag_N;
      OP_BGE:  taken = !flag_N;
      OP_BLT:  taken = flag_N;
      OP_BLE:  taken = flag_N || flag_Z;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the accumulator CPU; outputs are
// decoded combinationally from the registered state, opcode and flags.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  logic           clock,
  input  logic           control_reset,
  control_unit_if.master bus
);

  state_t                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] opcode_raw;
  opcode_t                 opcode;
  logic                    taken;

  assign opcode_raw = bus.opcode_in;
  assign opcode     = opcode_t'(opcode_raw);

  branch_condition u_branch_condition (
    .opcode (opcode),
    .flag_Z (bus.flag_Z),
    .flag_N (bus.flag_N),
    .taken  (taken)
  );

  always_comb begin
    unique case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = (opcode == OP_HLT) ? HALT : FETCH;
      default: state_d = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; the reset here is synchronous by design.
  always_ff @(posedge clock) begin
    if (control_reset) state_q <= FETCH;
    else               state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    bus.ir_wr       = 1'b0;
    bus.pc_wr       = 1'b0;
    bus.pc_src      = 1'b0;
    bus.acc_wr      = 1'b0;
    bus.acc_src     = ACC_MEM;
    bus.alu_op      = ALU_ADD;
    bus.alu_src     = 1'b0;
    bus.data_mem_wr = 1'b0;
    bus.status_wr   = 1'b0;
    bus.halted      = 1'b0;

    // Reset suppresses any in-flight write in the cycle it is applied.
    if (!control_reset) begin
      unique case (state_q)
        FETCH: bus.ir_wr = 1'b1;
        DECODE: ;
        EXEC: begin
          if (opcode != OP_HLT) begin
            bus.pc_wr  = 1'b1;
            bus.pc_src = taken;
          end
          unique case (opcode)
            OP_STO: bus.data_mem_wr = 1'b1;
            OP_LD: begin
              bus.acc_wr  = 1'b1;
              bus.acc_src = ACC_MEM;
            end
            OP_LDI: begin
              bus.acc_wr  = 1'b1;
              bus.acc_src = ACC_IMM;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
              bus.acc_wr    = 1'b1;
              bus.acc_src   = ACC_ALU;
              bus.status_wr = 1'b1;
              bus.alu_op    = (opcode == OP_SUB || opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
              bus.alu_src   = (opcode == OP_ADDI || opcode == OP_SUBI);
            end
            default: ;
          endcase
        end
        default: bus.halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-instruction FETCH/DECODE/EXEC
// outputs plus hand-written halt and reset sequences.
module tb_control_unit;

  // Output vector order: {ir_wr, pc_wr, pc_src, acc_wr, acc_src[1:0], alu_op, alu_src,
  //                       data_mem_wr, status_wr, halted}
  localparam logic [10:0] E_ZERO   = 11'b0_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] E_FETCH  = 11'b1_0_0_0_00_0_0_0_0_0;
  localparam logic [10:0] E_HALTED = 11'b0_0_0_0_00_0_0_0_0_1;
  localparam logic [10:0] E_TAKEN  = 11'b0_1_1_0_00_0_0_0_0_0;
  localparam logic [10:0] E_NOTKN  = 11'b0_1_0_0_00_0_0_0_0_0;

  typedef struct {
    string       name;
    logic [4:0]  opcode;
    logic        z;
    logic        n;
    logic [10:0] exp_exec;
  } vec_t;

  logic clock;
  logic control_reset;
  int   errors = 0;
  int   checks = 0;

  control_unit_if #(.OPCODE_WIDTH(5)) bus ();

  control_unit #(.OPCODE_WIDTH(5)) dut (
    .clock         (clock),
    .control_reset (control_reset),
    .bus           (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] outs();
    return {bus.ir_wr, bus.pc_wr, bus.pc_src, bus.acc_wr, bus.acc_src, bus.alu_op,
            bus.alu_src, bus.data_mem_wr, bus.status_wr, bus.halted};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Entered just after a posedge with the DUT in FETCH; leaves just after the
  // posedge that ends EXEC.
  task automatic run_instr(input vec_t v);
    bus.opcode_in = v.opcode;
    bus.flag_Z    = v.z;
    bus.flag_N    = v.n;
    @(negedge clock); check({v.name, " fetch"},  outs(), E_FETCH);
    @(negedge clock); check({v.name, " decode"}, outs(), E_ZERO);
    @(negedge clock); check({v.name, " exec"},   outs(), v.exp_exec);
    @(posedge clock); #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{"ldi",   5'b00011, 1'b0, 1'b0, 11'b0_1_0_1_01_0_0_0_0_0},
      '{"ld",    5'b00010, 1'b0, 1'b0, 11'b0_1_0_1_00_0_0_0_0_0},
      '{"sto",   5'b00001, 1'b0, 1'b0, 11'b0_1_0_0_00_0_0_1_0_0},
      '{"add",   5'b00100, 1'b0, 1'b0, 11'b0_1_0_1_10_0_0_0_1_0},
      '{"addi",  5'b00101, 1'b1, 1'b1, 11'b0_1_0_1_10_0_1_0_1_0},
      '{"sub",   5'b00110, 1'b0, 1'b0, 11'b0_1_0_1_10_1_0_0_1_0},
      '{"subi",  5'b00111, 1'b0, 1'b1, 11'b0_1_0_1_10_1_1_0_1_0},
      '{"beq z", 5'b01000, 1'b1, 1'b0, E_TAKEN},
      '{"bne z", 5'b01001, 1'b1, 1'b0, E_NOTKN},
      '{"bgt z", 5'b01010, 1'b1, 1'b0, E_NOTKN},
      '{"bge z", 5'b01011, 1'b1, 1'b0, E_TAKEN},
      '{"blt z", 5'b01100, 1'b1, 1'b0, E_NOTKN},
      '{"ble z", 5'b01101, 1'b1, 1'b0, E_TAKEN},
      '{"beq -", 5'b01000, 1'b0, 1'b0, E_NOTKN},
      '{"bne -", 5'b01001, 1'b0, 1'b1, E_TAKEN},
      '{"bgt -", 5'b01010, 1'b0, 1'b0, E_TAKEN},
      '{"bgt n", 5'b01010, 1'b0, 1'b1, E_NOTKN},
      '{"bge n", 5'b01011, 1'b0, 1'b1, E_NOTKN},
      '{"blt n", 5'b01100, 1'b0, 1'b1, E_TAKEN},
      '{"ble -", 5'b01101, 1'b0, 1'b0, E_NOTKN},
      '{"ble n", 5'b01101, 1'b0, 1'b1, E_TAKEN},
      '{"jmp 00", 5'b01110, 1'b0, 1'b0, E_TAKEN},
      '{"jmp 01", 5'b01110, 1'b0, 1'b1, E_TAKEN},
      '{"jmp 10", 5'b01110, 1'b1, 1'b0, E_TAKEN},
      '{"jmp 11", 5'b01110, 1'b1, 1'b1, E_TAKEN},
      '{"nop 1f", 5'b11111, 1'b1, 1'b1, E_NOTKN},
      '{"nop 0f", 5'b01111, 1'b0, 1'b0, E_NOTKN},
      '{"nop 10", 5'b10000, 1'b1, 1'b0, E_NOTKN}
    };

    control_reset = 1'b1;
    bus.opcode_in = 5'b00011;
    bus.flag_Z    = 1'b0;
    bus.flag_N    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); check("reset outputs", outs(), E_ZERO);
    @(posedge clock); #1;
    control_reset = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i]);

    // HLT: EXEC has no pc_wr, then HALT holds for 10 cycles whatever the opcode.
    bus.opcode_in = 5'b00000;
    @(negedge clock); check("hlt fetch",  outs(), E_FETCH);
    @(negedge clock); check("hlt decode", outs(), E_ZERO);
    @(negedge clock); check("hlt exec",   outs(), E_ZERO);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      bus.opcode_in = 5'($urandom_range(0, 31));
      bus.flag_Z    = 1'($urandom_range(0, 1));
      @(negedge clock); check($sformatf("halt hold %0d", c), outs(), E_HALTED);
    end
    @(posedge clock); #1;
    control_reset = 1'b1;
    @(negedge clock); check("halt under reset", outs(), E_ZERO);
    @(posedge clock); #1;
    control_reset = 1'b0;
    bus.opcode_in = 5'b00011;
    @(negedge clock); check("fetch after halt reset", outs(), E_FETCH);
    @(negedge clock); check("decode after halt reset", outs(), E_ZERO);
    @(posedge clock); @(posedge clock); #1;

    // Reset in the EXEC of STO suppresses the store and restarts at FETCH.
    bus.opcode_in = 5'b00001;
    @(negedge clock); check("sto fetch",  outs(), E_FETCH);
    @(negedge clock); check("sto decode", outs(), E_ZERO);
    @(posedge clock); #1;
    control_reset = 1'b1;
    @(negedge clock); check("sto exec under reset", outs(), E_ZERO);
    @(posedge clock); #1;
    control_reset = 1'b0;
    @(negedge clock); check("fetch after sto reset", outs(), E_FETCH);
    @(negedge clock); check("decode after sto reset", outs(), E_ZERO);
    @(negedge clock); check("sto exec after reset", outs(), 11'b0_1_0_0_00_0_0_1_0_0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
